// File: rtl/fpga_robots_game_sound.sv
// Multi-voice square-wave tone generator with a first-order sigma-delta output.
// Each voice plays a programmable half-period, volume and duration, paced by a
// shared timebase strobe. The voice samples are summed and the sum drives a
// 1-bit modulator.
module fpga_robots_game_sound #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CHW      = 1,
    parameter int unsigned DIVW     = 12,
    parameter int unsigned DURW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                cmd_stb,
    input  logic [CHW-1:0]      cmd_ch,
    input  logic [DIVW-1:0]     cmd_period,
    input  logic [DURW-1:0]     cmd_dur,
    input  logic [3:0]          cmd_vol,
    output logic [CHANNELS-1:0] busy,
    output logic [8+CHW-1:0]    mix,
    output logic                audio
);

    localparam int unsigned MIXW  = 8 + CHW;
    localparam int unsigned SAMPW = 8;

    typedef enum logic {
        V_IDLE = 1'b0,
        V_PLAY = 1'b1
    } voice_state_t;

    // Per-voice sample, 0..240.
    logic [SAMPW-1:0] samp_c [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
        voice_state_t    state_q, state_d;
        logic [DIVW-1:0] per_q,   per_d;
        logic [DIVW-1:0] cnt_q,   cnt_d;
        logic [DURW-1:0] dur_q,   dur_d;
        logic            cont_q,  cont_d;
        logic [3:0]      vol_q,   vol_d;
        logic            sq_q,    sq_d;
        logic            hit_c;

        // A command selects this voice only when its index matches exactly;
        // out-of-range indices never match any instantiated voice.
        assign hit_c = cmd_stb && (cmd_ch == CHW'(i));

        // Voice register bank.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= V_IDLE;
                per_q   <= '0;
                cnt_q   <= '0;
                dur_q   <= '0;
                cont_q  <= 1'b0;
                vol_q   <= '0;
                sq_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                per_q   <= per_d;
                cnt_q   <= cnt_d;
                dur_q   <= dur_d;
                cont_q  <= cont_d;
                vol_q   <= vol_d;
                sq_q    <= sq_d;
            end
        end

        // Next state: a command beats a tick; a note end beats the toggle.
        always_comb begin
            state_d = state_q;
            per_d   = per_q;
            cnt_d   = cnt_q;
            dur_d   = dur_q;
            cont_d  = cont_q;
            vol_d   = vol_q;
            sq_d    = sq_q;
            if (hit_c) begin
                if (cmd_period == '0) begin
                    state_d = V_IDLE;
                    sq_d    = 1'b0;
                end else begin
                    state_d = V_PLAY;
                    per_d   = cmd_period;
                    cnt_d   = cmd_period;
                    dur_d   = cmd_dur;
                    cont_d  = (cmd_dur == '0);
                    vol_d   = cmd_vol;
                    sq_d    = 1'b1;
                end
            end else if (tick && (state_q == V_PLAY)) begin
                if (cnt_q == DIVW'(1)) begin
                    cnt_d = per_q;
                    sq_d  = ~sq_q;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
                if (!cont_q) begin
                    if (dur_q == DURW'(1)) begin
                        state_d = V_IDLE;
                        sq_d    = 1'b0;
                    end else begin
                        dur_d = dur_q - DURW'(1);
                    end
                end
            end
        end

        assign samp_c[i] = ((state_q == V_PLAY) && sq_q) ? {vol_q, 4'h0} : '0;
        assign busy[i]   = (state_q == V_PLAY);
    end

    logic [MIXW-1:0] sum_c;
    logic [MIXW-1:0] acc_q;
    logic [MIXW:0]   acc_sum_c;

    // Sum all voice samples; 240 * 2^CHW always fits in MIXW bits.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            sum_c = sum_c + MIXW'(samp_c[i]);
        end
    end

    assign acc_sum_c = {1'b0, acc_q} + {1'b0, mix};

    // Registered mix and first-order sigma-delta; carry out is the audio bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mix   <= '0;
            acc_q <= '0;
            audio <= 1'b0;
        end else begin
            mix   <= sum_c;
            acc_q <= acc_sum_c[MIXW-1:0];
            audio <= acc_sum_c[MIXW];
        end
    end

endmodule

// File: tb/tb_fpga_robots_game_sound.sv
// Directed bench for the tone generator: reset, square/duration timing,
// continuous play and stop, mixing plus modulator density, collisions,
// out-of-range channel and reset in the middle of a note.
module tb_fpga_robots_game_sound;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        cmd_stb;
    logic [0:0]  cmd_ch;
    logic [11:0] cmd_period;
    logic [15:0] cmd_dur;
    logic [3:0]  cmd_vol;
    logic [1:0]  busy;
    logic [8:0]  mix;
    logic        audio;

    logic        t3_tick;
    logic        t3_stb;
    logic [1:0]  t3_ch;
    logic [11:0] t3_period;
    logic [15:0] t3_dur;
    logic [3:0]  t3_vol;
    logic [2:0]  t3_busy;
    logic [9:0]  t3_mix;
    logic        t3_audio;

    int total;
    int bad;
    int ones;

    fpga_robots_game_sound #(.CHANNELS(2), .CHW(1), .DIVW(12), .DURW(16)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .cmd_stb(cmd_stb), .cmd_ch(cmd_ch),
        .cmd_period(cmd_period), .cmd_dur(cmd_dur), .cmd_vol(cmd_vol),
        .busy(busy), .mix(mix), .audio(audio)
    );

    fpga_robots_game_sound #(.CHANNELS(3), .CHW(2), .DIVW(12), .DURW(16)) u_dut3 (
        .clk(clk), .rst(rst), .tick(t3_tick), .cmd_stb(t3_stb), .cmd_ch(t3_ch),
        .cmd_period(t3_period), .cmd_dur(t3_dur), .cmd_vol(t3_vol),
        .busy(t3_busy), .mix(t3_mix), .audio(t3_audio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(negedge clk);
    endtask

    task automatic cmd(input logic [0:0] ch, input logic [11:0] p, input logic [15:0] d,
                       input logic [3:0] v, input logic tk);
        cmd_stb    = 1'b1;
        cmd_ch     = ch;
        cmd_period = p;
        cmd_dur    = d;
        cmd_vol    = v;
        tick       = tk;
        @(negedge clk);
        cmd_stb    = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic cmd3(input logic [1:0] ch, input logic [11:0] p, input logic [3:0] v);
        t3_stb    = 1'b1;
        t3_ch     = ch;
        t3_period = p;
        t3_dur    = 16'd0;
        t3_vol    = v;
        @(negedge clk);
        t3_stb    = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        ones       = 0;
        rst        = 1'b0;
        tick       = 1'b1;
        cmd_stb    = 1'b1;
        cmd_ch     = 1'b0;
        cmd_period = 12'd3;
        cmd_dur    = 16'd0;
        cmd_vol    = 4'd15;
        t3_tick    = 1'b0;
        t3_stb     = 1'b0;
        t3_ch      = 2'd0;
        t3_period  = 12'd0;
        t3_dur     = 16'd0;
        t3_vol     = 4'd0;

        // 1. Reset held for 3 clk with command and tick asserted.
        for (int k = 0; k < 3; k++) begin
            clk1();
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_mix", 32'(mix), 32'd0);
            check("rst_audio", 32'(audio), 32'd0);
        end
        rst     = 1'b1;
        cmd_stb = 1'b0;
        tick    = 1'b0;
        clk1();
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_mix", 32'(mix), 32'd0);
        check("rel_audio", 32'(audio), 32'd0);
        check("rst3_busy", 32'(t3_busy), 32'd0);

        // 2. Square wave with duration: period 3, 12 ticks, full volume.
        cmd(1'b0, 12'd3, 16'd12, 4'd15, 1'b0);
        check("sq_busy_start", 32'(busy), 32'd1);
        clk1();
        check("sq_mix_t0", 32'(mix), 32'd240);
        for (int k = 1; k <= 11; k++) begin
            do_tick();
            clk1();
            check($sformatf("sq_mix_t%0d", k), 32'(mix), (((k / 3) % 2) == 0) ? 32'd240 : 32'd0);
            check($sformatf("sq_busy_t%0d", k), 32'(busy), 32'd1);
            clk1();
            clk1();
        end
        do_tick();
        check("sq_busy_end", 32'(busy), 32'd0);
        clk1();
        check("sq_mix_end", 32'(mix), 32'd0);
        do_tick();
        clk1();
        check("sq_mix_after", 32'(mix), 32'd0);

        // 3. Continuous note on ch1 at period 1, then stop.
        cmd(1'b1, 12'd1, 16'd0, 4'd8, 1'b0);
        check("cont_busy", 32'(busy), 32'd2);
        clk1();
        check("cont_mix_t0", 32'(mix), 32'd128);
        for (int k = 1; k <= 100; k++) begin
            do_tick();
            clk1();
            check($sformatf("cont_mix_t%0d", k), 32'(mix), ((k % 2) == 0) ? 32'd128 : 32'd0);
        end
        check("cont_busy_100", 32'(busy), 32'd2);
        cmd(1'b1, 12'd0, 16'd0, 4'd8, 1'b0);
        check("stop_busy", 32'(busy), 32'd0);
        clk1();
        check("stop_mix", 32'(mix), 32'd0);

        // 4. Both voices at full volume; modulator density over 512 clk.
        cmd(1'b0, 12'd4095, 16'd0, 4'd15, 1'b0);
        cmd(1'b1, 12'd4095, 16'd0, 4'd15, 1'b0);
        check("both_busy", 32'(busy), 32'd3);
        clk1();
        clk1();
        clk1();
        check("both_mix", 32'(mix), 32'd480);
        for (int k = 0; k < 512; k++) begin
            clk1();
            if (audio === 1'b1) ones++;
        end
        check("sd_density", 32'(ones), 32'd480);
        check("both_mix_hold", 32'(mix), 32'd480);

        // 5a. Command and tick in the same cycle; ch1 keeps ticking.
        cmd(1'b0, 12'd0, 16'd0, 4'd0, 1'b0);
        cmd(1'b1, 12'd1, 16'd0, 4'd1, 1'b0);
        clk1();
        check("col_pre_mix", 32'(mix), 32'd16);
        cmd(1'b0, 12'd2, 16'd0, 4'd15, 1'b1);
        check("col_busy", 32'(busy), 32'd3);
        clk1();
        check("col_mix_c", 32'(mix), 32'd240);
        do_tick();
        clk1();
        check("col_mix_t1", 32'(mix), 32'd256);
        do_tick();
        clk1();
        check("col_mix_t2", 32'(mix), 32'd0);
        do_tick();
        clk1();
        check("col_mix_t3", 32'(mix), 32'd16);
        do_tick();
        clk1();
        check("col_mix_t4", 32'(mix), 32'd240);

        // 5b. Three-voice instance: index 3 is out of range.
        cmd3(2'd2, 12'd5, 4'd15);
        check("ch3_busy_start", 32'(t3_busy), 32'd4);
        clk1();
        check("ch3_mix_start", 32'(t3_mix), 32'd240);
        cmd3(2'd3, 12'd7, 4'd15);
        check("ch3_ign_busy", 32'(t3_busy), 32'd4);
        cmd3(2'd3, 12'd0, 4'd0);
        check("ch3_ign_stop", 32'(t3_busy), 32'd4);
        clk1();
        check("ch3_ign_mix", 32'(t3_mix), 32'd240);

        // 6. Reset in the middle of a note.
        cmd(1'b1, 12'd0, 16'd0, 4'd0, 1'b0);
        cmd(1'b0, 12'd3, 16'd0, 4'd15, 1'b0);
        clk1();
        check("mid_busy_pre", 32'(busy), 32'd1);
        check("mid_mix_pre", 32'(mix), 32'd240);
        rst = 1'b0;
        clk1();
        rst = 1'b1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid3_busy", 32'(t3_busy), 32'd0);
        clk1();
        check("mid_mix", 32'(mix), 32'd0);
        for (int k = 0; k < 8; k++) begin
            do_tick();
            clk1();
            check($sformatf("mid_quiet_mix%0d", k), 32'(mix), 32'd0);
            check($sformatf("mid_quiet_audio%0d", k), 32'(audio), 32'd0);
        end
        check("mid_quiet_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
